// File: rtl/fpdiv_pkg.sv
// -----------------------------------------------------------------------------
// fpdiv_pkg
// Shared types and constants for the sequential binary32 divider.
//   state_t     : controller states (IDLE, PREP, DIV, PACK)
//   EXC_*       : EXCEPTION output codes
//   QNAN        : canonical quiet NaN returned for invalid operations
//   EXP_MAX     : all-ones biased exponent (inf/NaN encoding)
//   BIAS        : binary32 exponent bias
// -----------------------------------------------------------------------------
package fpdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      DIV  = 2'd2,
      PACK = 2'd3
   } state_t;

   localparam logic [1:0] EXC_NONE  = 2'b00;
   localparam logic [1:0] EXC_DIVZ  = 2'b01;
   localparam logic [1:0] EXC_INV   = 2'b10;
   localparam logic [1:0] EXC_RANGE = 2'b11;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam int          EXP_MAX = 255;
   localparam int          BIAS    = 127;

endpackage

// File: rtl/fpdiv_mant_step.sv
// -----------------------------------------------------------------------------
// fpdiv_mant_step
// One restoring-division step on the mantissa remainder (combinational).
// Ports:
//   rem     in  MANT_W+2  current partial remainder (always < 2*mb)
//   mb      in  MANT_W+1  divisor mantissa including the hidden 1
//   rem_nxt out MANT_W+2  remainder for the next step, already shifted left
//   qbit    out 1         quotient bit produced by this step
// -----------------------------------------------------------------------------
module fpdiv_mant_step #(
   parameter int MANT_W = 23
) (
   input  logic [MANT_W+1:0] rem,
   input  logic [MANT_W:0]   mb,
   output logic [MANT_W+1:0] rem_nxt,
   output logic              qbit
);
   import fpdiv_pkg::*;

   logic signed [MANT_W+2:0] diff;

   always_comb begin
      diff    = $signed({1'b0, rem}) - $signed({2'b00, mb});
      qbit    = ~diff[MANT_W+2];
      // The kept value is always below mb, so the left shift cannot lose a 1.
      rem_nxt = qbit ? (diff[MANT_W+1:0] << 1) : (rem << 1);
   end

endmodule

// File: rtl/fpdiv_seq.sv
// -----------------------------------------------------------------------------
// fpdiv_seq
// Sequential IEEE-754 binary32 divider: operand capture, special-case
// classification, restoring mantissa division (one quotient bit per cycle),
// exponent range check and result packing.
// Ports:
//   CLOCK     in  1   rising-edge clock
//   RESET     in  1   synchronous, active-low reset
//   START     in  1   request, sampled only in IDLE
//   InputA    in  32  dividend, captured on acceptance
//   InputB    in  32  divisor, captured on acceptance
//   BUSY      out 1   high from acceptance until the DONE cycle
//   DONE      out 1   one-cycle result-valid pulse
//   AbyB      out 32  quotient, held until the next result
//   EXCEPTION out 2   00 none, 01 div-by-zero, 10 invalid, 11 over/underflow
// Build option:
//   FPDIV_ROUND_EN  defined   -> 26 iterations, round to nearest even
//                   undefined -> 24 iterations, truncation
// -----------------------------------------------------------------------------
module fpdiv_seq #(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int BIAS   = fpdiv_pkg::BIAS
) (
   input  logic                    CLOCK,
   input  logic                    RESET,
   input  logic                    START,
   input  logic [EXP_W+MANT_W:0]   InputA,
   input  logic [EXP_W+MANT_W:0]   InputB,
   output logic                    BUSY,
   output logic                    DONE,
   output logic [EXP_W+MANT_W:0]   AbyB,
   output logic [1:0]              EXCEPTION
);
   import fpdiv_pkg::*;

   localparam int WORD_W = EXP_W + MANT_W + 1;
   localparam int MW     = MANT_W + 1;     // mantissa with hidden 1
   localparam int EW     = EXP_W + 2;      // signed working exponent
`ifdef FPDIV_ROUND_EN
   localparam int ITER   = MW + 2;         // guard and round bits
`else
   localparam int ITER   = MW;
`endif
   // The leading quotient bit is always 1, so it is shifted out of q.
   localparam int QB     = ITER - 1;
   localparam int CNT_W  = $clog2(ITER);

   localparam logic [EXP_W-1:0]    EMAX_F  = EXP_W'(EXP_MAX);
   localparam logic signed [EW-1:0] E_ZERO = '0;
   localparam logic signed [EW-1:0] E_MAX  = EW'(EXP_MAX);

   state_t                 state;
   logic [WORD_W-1:0]      a_r, b_r;
   logic                   spec_flag;
   logic [MW:0]            rem;
   logic [MW-1:0]          mb;
   logic [QB-1:0]          q;
   logic [CNT_W-1:0]       cnt;
   logic signed [EW-1:0]   e;

   // operand fields
   logic                   sa, sb, sign;
   logic [EXP_W-1:0]       ea, eb;
   logic [MANT_W-1:0]      fa, fb;
   logic                   za, zb, ia, ib, na, nb;
   logic [MW-1:0]          ma, mbv;
   logic                   adj;
   logic signed [EW-1:0]   e_calc;

   logic                   spec_hit;
   logic [WORD_W-1:0]      spec_word;
   logic [1:0]             spec_exc;
   logic [WORD_W-1:0]      inf_word, zero_word;

   logic [MW:0]            rem_nxt;
   logic                   qbit;

   logic signed [EW-1:0]   e_fin;
   logic [MANT_W-1:0]      mant;
   logic [WORD_W-1:0]      norm_word;
   logic [1:0]             norm_exc;

`ifdef FPDIV_ROUND_EN
   logic [MANT_W:0]        rnd;

   // Round to nearest, ties to even; bit MANT_W of the result is the carry
   // out of the stored mantissa (1.111..1 + ulp = 10.000..0).
   function automatic logic [MANT_W:0] round_rne(input logic [MANT_W+1:0] qv,
                                                 input logic sticky);
      logic inc;
      inc = qv[1] & (qv[0] | sticky | qv[2]);
      return {1'b0, qv[MANT_W+1:2]} + {{MANT_W{1'b0}}, inc};
   endfunction
`endif

   assign sa   = a_r[WORD_W-1];
   assign sb   = b_r[WORD_W-1];
   assign ea   = a_r[WORD_W-2 -: EXP_W];
   assign eb   = b_r[WORD_W-2 -: EXP_W];
   assign fa   = a_r[MANT_W-1:0];
   assign fb   = b_r[MANT_W-1:0];
   assign sign = sa ^ sb;

   // Exponent 0 is treated as zero regardless of the fraction (flush).
   assign za = (ea == '0);
   assign zb = (eb == '0);
   assign ia = (ea == EMAX_F) && (fa == '0);
   assign ib = (eb == EMAX_F) && (fb == '0);
   assign na = (ea == EMAX_F) && (fa != '0);
   assign nb = (eb == EMAX_F) && (fb != '0);

   assign inf_word  = {sign, EMAX_F, {MANT_W{1'b0}}};
   assign zero_word = {sign, {(WORD_W-1){1'b0}}};

   assign ma  = {1'b1, fa};
   assign mbv = {1'b1, fb};
   assign adj = (ma < mbv);

   always_comb begin
      e_calc = $signed({2'b00, ea}) - $signed({2'b00, eb})
             + $signed(EW'(BIAS)) - $signed({{(EW-1){1'b0}}, adj});
   end

   // Special-case classification; priority matters (inf/0 is a plain inf).
   always_comb begin
      spec_hit  = 1'b1;
      spec_word = '0;
      spec_exc  = EXC_NONE;
      if (na || nb || (za && zb) || (ia && ib)) begin
         spec_word = QNAN;
         spec_exc  = EXC_INV;
      end else if (ia) begin
         spec_word = inf_word;
      end else if (zb) begin
         spec_word = inf_word;
         spec_exc  = EXC_DIVZ;
      end else if (za || ib) begin
         spec_word = zero_word;
      end else begin
         spec_hit  = 1'b0;
      end
   end

   fpdiv_mant_step #(.MANT_W(MANT_W)) u_step (
      .rem     (rem),
      .mb      (mb),
      .rem_nxt (rem_nxt),
      .qbit    (qbit)
   );

   // Normal-path packing with the exponent range check.
   always_comb begin
`ifdef FPDIV_ROUND_EN
      rnd   = round_rne(q, |rem);
      mant  = rnd[MANT_W-1:0];
      e_fin = e + $signed({{(EW-1){1'b0}}, rnd[MANT_W]});
`else
      mant  = q;
      e_fin = e;
`endif
      if (e_fin <= E_ZERO) begin
         norm_word = zero_word;
         norm_exc  = EXC_RANGE;
      end else if (e_fin >= E_MAX) begin
         norm_word = inf_word;
         norm_exc  = EXC_RANGE;
      end else begin
         norm_word = {sign, e_fin[EXP_W-1:0], mant};
         norm_exc  = EXC_NONE;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state     <= IDLE;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         AbyB      <= '0;
         EXCEPTION <= EXC_NONE;
      end else begin
         DONE <= 1'b0;
         case (state)
            // capture operands
            IDLE: begin
               if (START) begin
                  a_r   <= InputA;
                  b_r   <= InputB;
                  BUSY  <= 1'b1;
                  state <= PREP;
               end
            end
            // classify, align mantissa, form exponent
            PREP: begin
               spec_flag <= spec_hit;
               if (spec_hit) begin
                  state <= PACK;
               end else begin
                  rem   <= adj ? {ma, 1'b0} : {1'b0, ma};
                  mb    <= mbv;
                  e     <= e_calc;
                  q     <= '0;
                  cnt   <= '0;
                  state <= DIV;
               end
            end
            // one quotient bit per cycle
            DIV: begin
               rem <= rem_nxt;
               q   <= {q[QB-2:0], qbit};
               if (cnt == CNT_W'(ITER-1)) begin
                  state <= PACK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // publish result
            PACK: begin
               AbyB      <= spec_flag ? spec_word : norm_word;
               EXCEPTION <= spec_flag ? spec_exc  : norm_exc;
               DONE      <= 1'b1;
               BUSY      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpdiv_seq.sv
module tb_fpdiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] ina, inb;
   logic        busy, done;
   logic [31:0] aby;
   logic [1:0]  exc;

   int errors = 0;
   int checks = 0;
   int dones  = 0;
   int cyc    = 0;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [1:0]  exc;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sbq[$];

`ifdef FPDIV_ROUND_EN
   localparam int          LAT   = 28;
   localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
   localparam int          LAT   = 26;
   localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpdiv_seq dut (
      .CLOCK     (clk),
      .RESET     (rst_n),
      .START     (start),
      .InputA    (ina),
      .InputB    (inb),
      .BUSY      (busy),
      .DONE      (done),
      .AbyB      (aby),
      .EXCEPTION (exc)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // monitor: pops the scoreboard on every DONE pulse
   always @(negedge clk) begin : mon
      exp_t e;
      if (done === 1'b1) begin
         dones++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=%h required=no_done", aby);
         end else begin
            e = sbq.pop_front();
            chk({e.name, "_result"},   aby,                 e.res);
            chk({e.name, "_exc"},      32'(exc),            32'(e.exc));
            chk({e.name, "_latency"},  32'(cyc - e.acc),    32'(e.lat));
            chk({e.name, "_busy_low"}, 32'(busy),           32'd0);
         end
      end
   end

   task automatic start_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [1:0] x, input int lat);
      exp_t e;
      @(negedge clk);
      ina   = a;
      inb   = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e.name = nm;
      e.res  = r;
      e.exc  = x;
      e.lat  = lat;
      e.acc  = cyc;
      sbq.push_back(e);
      chk({nm, "_busy_accept"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (dones < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("done_within_budget", 32'(dones >= target), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      ina   = '0;
      inb   = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_abyb", aby,       32'd0);
      chk("reset_exc",  32'(exc),  32'd0);
      rst_n = 1'b1;

      start_op("div6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, LAT);
      repeat (10) @(negedge clk);
      chk("div6_2_busy_mid", 32'(busy), 32'd1);
      wait_done(1);

      start_op("div1_3", 32'h3F800000, 32'h40400000, THIRD, 2'b00, LAT);
      wait_done(2);
      start_op("div5_0", 32'h40A00000, 32'h00000000, 32'h7F800000, 2'b01, 2);
      wait_done(3);
      start_op("div0_0", 32'h00000000, 32'h00000000, 32'h7FC00000, 2'b10, 2);
      wait_done(4);
      start_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 2'b11, LAT);
      wait_done(5);
      start_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 2'b11, LAT);
      wait_done(6);

      // stray START while busy must be ignored
      start_op("neg1p5_0p5", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 2'b00, LAT);
      repeat (5) @(negedge clk);
      ina   = 32'h3F800000;
      inb   = 32'h40400000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(7);
      repeat (40) @(negedge clk);
      chk("single_done", 32'(dones), 32'd7);
      chk("queue_empty", 32'(sbq.size()), 32'd0);

      // reset in the middle of DIV discards the operation
      start_op("aborted", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, LAT);
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      sbq.delete(sbq.size() - 1);
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_abyb", aby,       32'd0);
      chk("abort_exc",  32'(exc),  32'd0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_done_after_abort", 32'(dones), 32'd7);

      start_op("div6_2_again", 32'h40C00000, 32'h40000000, 32'h40400000, 2'b00, LAT);
      wait_done(8);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
